db_req_queue: RTL and testbench
===============================

Name: db_req_queue

Overview:
- Lookup front-end between the packet parser (eth_encap) and the key-value DB.
- Buffers the parser's single-cycle lookup pulses (in_key/in_flag/in_valid) in a small FIFO and issues them to the DB one at a time with a valid/ready handshake.
- Waits for each DB reply, with a timeout, and returns it to the parser as out_valid/out_flag.
- The parser has no backpressure, so the block absorbs bursts and counts requests it drops.

Parameters:
KEY_SIZE, 96, lookup key width in bits
FIFO_AW, 3, log2 of request FIFO depth (depth = 2**FIFO_AW = 8)
TIMEOUT, 256, cycles to wait for a DB reply before a synthesized miss; must be >= 2

Ports:
clk156  input  1  clock; all logic on rising edge
eth_rst_n  input  1  synchronous active-low reset
in_key  input  KEY_SIZE  lookup key from parser
in_flag  input  4  op flags from parser
in_valid  input  1  one-cycle request strobe; no ready returned
db_req_valid  output  1  request to DB valid
db_req_ready  input  1  DB accepts request
db_req_key  output  KEY_SIZE  key to DB
db_req_flag  output  4  op flags to DB
db_rsp_valid  input  1  DB reply strobe
db_rsp_flag  input  4  DB reply flags
out_valid  output  1  one-cycle reply strobe to parser
out_flag  output  4  reply flags to parser; [2:1]==2'b10 means filter
out_key  output  KEY_SIZE  key that the current out_valid answers
busy  output  1  high when FSM not IDLE or FIFO not empty
drop_cnt  output  16  requests dropped on FIFO full, saturating
timeout_cnt  output  16  replies synthesized by timeout, saturating

Behaviour:
- Reset (eth_rst_n==0 at a clock edge):
  - All outputs 0, FSM to IDLE.
  - FIFO pointers and count 0, timer 0, counters 0.
  - Reset mid-transaction abandons the request with no out_valid.
  - A DB reply arriving after reset is ignored.
- FIFO:
  - Entry = {in_flag, in_key}; count is FIFO_AW+1 bits.
  - Write when in_valid && count != 2**FIFO_AW, evaluated on the registered count.
  - A write while full is dropped and drop_cnt increments, saturating at 16'hFFFF. This holds even if a pop occurs in the same cycle.
  - Simultaneous push and pop when not full: count unchanged.
  - Pointers wrap modulo depth.
- FSM states IDLE, ISSUE, WAIT:
  - IDLE, FIFO not empty: pop head into db_req_key/db_req_flag, go ISSUE.
  - IDLE, FIFO empty: stay.
  - ISSUE: db_req_valid=1 and key/flag held stable. When db_req_ready=1 the handshake completes that cycle: go WAIT, timer=0, db_req_valid=0 next cycle. db_req_valid never drops before ready.
  - WAIT, db_rsp_valid=1: next cycle out_valid=1, out_flag=db_rsp_flag, out_key=issued key; go IDLE.
  - WAIT, no reply: timer increments. When timer==TIMEOUT-1 with no reply that cycle: next cycle out_valid=1, out_flag=4'b0000, out_key=issued key; timeout_cnt increments (saturating); go IDLE.
  - A reply and timer expiry in the same cycle: the reply wins and timeout_cnt does not increment.
- db_rsp_valid in IDLE or ISSUE is stray: ignored, no out_valid.
- At most one request outstanding.
- out_valid is a single-cycle pulse. out_flag and out_key hold their last value until the next pulse.
- Latency, empty queue with ready tied high:
  - in_valid at cycle 0 → db_req_valid high in cycle 2, accepted in cycle 2.
  - Reply in cycle N → out_valid in cycle N+1.
  - Back-to-back requests: next db_req_valid no earlier than 2 cycles after out_valid.
- busy is combinational: (state != IDLE) || (count != 0).

Test Plan:
- Single lookup: in_valid with key 96'h0A000001_0A000002_3039_0000, flag 4'b0011; ready=1; reply flag 4'b0100 three cycles after accept → db_req_valid in cycle 2 with the same key/flag; out_valid one cycle after reply with out_flag=4'b0100 and out_key equal to the key; busy low afterwards.
- Backpressure: hold db_req_ready=0 for 5 cycles → db_req_valid stays 1 and key/flag stay stable; one handshake only on ready.
- Overflow: ready=0, 10 consecutive in_valid pulses → FIFO holds 8, drop_cnt=2; after releasing ready and answering all, exactly 8 out_valid pulses in push order.
- Timeout: TIMEOUT=16, no reply → out_valid exactly 16 cycles after the accept cycle, out_flag=4'b0000, timeout_cnt=1; a late reply 3 cycles later gives no out_valid.
- Race: reply in the same cycle the timer reaches TIMEOUT-1 → out_flag equals the reply flag, timeout_cnt unchanged; a stray reply in IDLE gives no output.
- Reset mid-WAIT: assert eth_rst_n=0 for 1 cycle, then send a reply → no out_valid, all counters 0, busy=0.

Source files
------------

// File: rtl/db_req_queue_if.sv
// Signal bundle between the parser/DB environment and db_req_queue.
// The queue takes the slave side; the environment drives the master side.
interface db_req_queue_if #(
  parameter int KEY_SIZE = 96
);
  logic [KEY_SIZE-1:0] in_key;
  logic [3:0]          in_flag;
  logic                in_valid;
  logic                db_req_valid;
  logic                db_req_ready;
  logic [KEY_SIZE-1:0] db_req_key;
  logic [3:0]          db_req_flag;
  logic                db_rsp_valid;
  logic [3:0]          db_rsp_flag;
  logic                out_valid;
  logic [3:0]          out_flag;
  logic [KEY_SIZE-1:0] out_key;
  logic                busy;
  logic [15:0]         drop_cnt;
  logic [15:0]         timeout_cnt;

  modport slave (
    input  in_key, in_flag, in_valid, db_req_ready, db_rsp_valid, db_rsp_flag,
    output db_req_valid, db_req_key, db_req_flag, out_valid, out_flag, out_key,
           busy, drop_cnt, timeout_cnt
  );

  modport master (
    output in_key, in_flag, in_valid, db_req_ready, db_rsp_valid, db_rsp_flag,
    input  db_req_valid, db_req_key, db_req_flag, out_valid, out_flag, out_key,
           busy, drop_cnt, timeout_cnt
  );
endinterface

// File: rtl/db_req_queue.sv
// Lookup request queue: buffers parser strobes in a FIFO, issues them to the DB
// one at a time, and returns the DB reply (or a synthesized miss on timeout).
module db_req_queue #(
  parameter int KEY_SIZE = 96,
  parameter int FIFO_AW  = 3,
  parameter int TIMEOUT  = 256
) (
  input  logic          clk156,
  input  logic          eth_rst_n,
  db_req_queue_if.slave bus
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int TW    = $clog2(TIMEOUT);
  localparam int EW    = KEY_SIZE + 4;
  localparam logic [FIFO_AW:0] FULL = (FIFO_AW+1)'(DEPTH);
  localparam logic [TW-1:0]    TMAX = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t              state, state_n;
  logic [EW-1:0]       mem [DEPTH];
  logic [FIFO_AW-1:0]  wr_ptr, rd_ptr;
  logic [FIFO_AW:0]    count;
  logic [TW-1:0]       timer;
  logic [KEY_SIZE-1:0] req_key;
  logic [3:0]          req_flag;
  logic                out_vld;
  logic [3:0]          out_flg;
  logic [KEY_SIZE-1:0] out_k;
  logic [15:0]         drop_cnt, timeout_cnt;

  logic push, drop, pop, accept, rsp_hit, expire;

  assign push    = bus.in_valid && (count != FULL);
  assign drop    = bus.in_valid && (count == FULL);
  // Hold off the pop in the cycle out_valid pulses so back-to-back requests
  // leave at least a two-cycle gap after each reply.
  assign pop     = (state == S_IDLE) && (count != '0) && !out_vld;
  assign accept  = (state == S_ISSUE) && bus.db_req_ready;
  assign rsp_hit = (state == S_WAIT) && bus.db_rsp_valid;
  assign expire  = (state == S_WAIT) && !bus.db_rsp_valid && (timer == TMAX);

  always_ff @(posedge clk156) begin
    if (!eth_rst_n) state <= S_IDLE;
    else            state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (pop)                state_n = S_ISSUE;
      S_ISSUE: if (bus.db_req_ready)   state_n = S_WAIT;
      S_WAIT:  if (rsp_hit || expire)  state_n = S_IDLE;
      default:                         state_n = S_IDLE;
    endcase
  end

  always_comb begin
    bus.db_req_valid = (state == S_ISSUE);
    bus.busy         = (state != S_IDLE) || (count != '0);
  end

  always_ff @(posedge clk156) begin
    if (push) mem[wr_ptr] <= {bus.in_flag, bus.in_key};
  end

  always_ff @(posedge clk156) begin
    if (!eth_rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      timer       <= '0;
      req_key     <= '0;
      req_flag    <= '0;
      out_vld     <= 1'b0;
      out_flg     <= '0;
      out_k       <= '0;
      drop_cnt    <= '0;
      timeout_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        {req_flag, req_key} <= mem[rd_ptr];
        rd_ptr              <= rd_ptr + 1'b1;
      end
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;

      if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;

      // Timer reads 0 in the accept cycle and counts every cycle after it,
      // so a miss is synthesized TIMEOUT cycles after the handshake.
      if (accept || (state == S_WAIT && !rsp_hit && !expire)) timer <= timer + 1'b1;
      else                                                      timer <= '0;

      out_vld <= rsp_hit || expire;
      if (rsp_hit) begin
        out_flg <= bus.db_rsp_flag;
        out_k   <= req_key;
      end else if (expire) begin
        out_flg <= 4'b0000;
        out_k   <= req_key;
        if (timeout_cnt != 16'hFFFF) timeout_cnt <= timeout_cnt + 16'd1;
      end
    end
  end

  assign bus.db_req_key  = req_key;
  assign bus.db_req_flag = req_flag;
  assign bus.out_valid   = out_vld;
  assign bus.out_flag    = out_flg;
  assign bus.out_key     = out_k;
  assign bus.drop_cnt    = drop_cnt;
  assign bus.timeout_cnt = timeout_cnt;
endmodule

// File: tb/tb_db_req_queue.sv
// Directed bench for db_req_queue with request/response scoreboards.
module tb_db_req_queue;
  localparam int KS = 96;

  logic clk156 = 1'b0;
  logic eth_rst_n = 1'b0;
  always #5 clk156 = ~clk156;

  db_req_queue_if #(.KEY_SIZE(KS)) bus();

  db_req_queue #(.KEY_SIZE(KS), .FIFO_AW(3), .TIMEOUT(16)) dut (
    .clk156    (clk156),
    .eth_rst_n (eth_rst_n),
    .bus       (bus)
  );

  int n_chk = 0;
  int n_fail = 0;
  int hs_cnt = 0;
  int out_cnt = 0;
  int cyc = 0;
  int last_out = -1;
  logic prev_req = 1'b0;
  logic [KS+3:0] req_q[$];
  logic [KS+3:0] rsp_q[$];
  logic [KS-1:0] cur_key = '0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk156);
    #1;
  endtask

  // Monitor at the falling edge: handshakes and replies against the scoreboards.
  always @(negedge clk156) begin
    logic [KS+3:0] e;
    cyc++;
    if (bus.db_req_valid && !prev_req && last_out >= 0)
      chk("req_gap_ge2", 128'((cyc - last_out) >= 2), 128'(1));
    prev_req = bus.db_req_valid;
    if (bus.db_req_valid && bus.db_req_ready) begin
      hs_cnt++;
      chk("req_expected", 128'(req_q.size() != 0), 128'(1));
      if (req_q.size() != 0) begin
        e = req_q.pop_front();
        chk("req_key", 128'(bus.db_req_key), 128'(e[KS-1:0]));
        chk("req_flag", 128'(bus.db_req_flag), 128'(e[KS+3:KS]));
        cur_key = e[KS-1:0];
      end
    end
    if (bus.out_valid) begin
      out_cnt++;
      last_out = cyc;
      chk("out_expected", 128'(rsp_q.size() != 0), 128'(1));
      if (rsp_q.size() != 0) begin
        e = rsp_q.pop_front();
        chk("out_key", 128'(bus.out_key), 128'(e[KS-1:0]));
        chk("out_flag", 128'(bus.out_flag), 128'(e[KS+3:KS]));
      end
    end
  end

  task automatic send(input logic [KS-1:0] k, input logic [3:0] f, input bit accepted);
    bus.in_key = k;
    bus.in_flag = f;
    bus.in_valid = 1'b1;
    if (accepted) req_q.push_back({f, k});
  endtask

  task automatic wait_hs(input int target);
    int n = 0;
    while (hs_cnt < target && n < 60) begin
      tick();
      n++;
    end
    chk("hs_wait", 128'(hs_cnt), 128'(target));
  endtask

  task automatic reply(input logic [3:0] f);
    bus.db_rsp_valid = 1'b1;
    bus.db_rsp_flag = f;
    rsp_q.push_back({f, cur_key});
    tick();
    bus.db_rsp_valid = 1'b0;
  endtask

  localparam logic [KS-1:0] K1 = 96'h0A000001_0A000002_3039_0000;
  localparam logic [KS-1:0] K2 = 96'hDEADBEEF_00112233_4455_6677;

  initial begin
    int t, o;
    bus.in_key = '0; bus.in_flag = '0; bus.in_valid = 1'b0;
    bus.db_req_ready = 1'b0; bus.db_rsp_valid = 1'b0; bus.db_rsp_flag = '0;
    tick(); tick();
    chk("rst_req_valid", 128'(bus.db_req_valid), 128'(0));
    chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("rst_busy", 128'(bus.busy), 128'(0));
    chk("rst_drop", 128'(bus.drop_cnt), 128'(0));
    chk("rst_tmo", 128'(bus.timeout_cnt), 128'(0));
    chk("rst_out_key", 128'(bus.out_key), 128'(0));
    eth_rst_n = 1'b1;
    tick();

    // Single lookup, ready tied high
    bus.db_req_ready = 1'b1;
    send(K1, 4'b0011, 1'b1);                 // cycle 0
    tick(); bus.in_valid = 1'b0;             // cycle 1
    chk("t1_busy_c1", 128'(bus.busy), 128'(1));
    chk("t1_req_c1", 128'(bus.db_req_valid), 128'(0));
    tick();                                  // cycle 2
    chk("t1_req_c2", 128'(bus.db_req_valid), 128'(1));
    chk("t1_key_c2", 128'(bus.db_req_key), 128'(K1));
    tick();                                  // cycle 3
    chk("t1_req_c3", 128'(bus.db_req_valid), 128'(0));
    tick(); tick();                          // cycle 5
    reply(4'b0100);                          // cycle 6
    chk("t1_out_valid", 128'(bus.out_valid), 128'(1));
    chk("t1_out_flag", 128'(bus.out_flag), 128'(4'b0100));
    tick();
    chk("t1_out_pulse", 128'(bus.out_valid), 128'(0));
    chk("t1_out_hold", 128'(bus.out_key), 128'(K1));
    chk("t1_busy_end", 128'(bus.busy), 128'(0));

    // Backpressure
    bus.db_req_ready = 1'b0;
    t = hs_cnt;
    send(K2, 4'b0101, 1'b1);
    tick(); bus.in_valid = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 128'(bus.db_req_valid), 128'(1));
      chk("bp_key", 128'(bus.db_req_key), 128'(K2));
      chk("bp_flag", 128'(bus.db_req_flag), 128'(4'b0101));
      tick();
    end
    chk("bp_no_hs", 128'(hs_cnt), 128'(t));
    bus.db_req_ready = 1'b1;
    tick();
    chk("bp_one_hs", 128'(hs_cnt), 128'(t + 1));
    chk("bp_valid_drop", 128'(bus.db_req_valid), 128'(0));
    reply(4'b1001);
    chk("bp_out", 128'(bus.out_valid), 128'(1));
    tick(); tick();

    // Overflow: one request parked in ISSUE, then 10 pulses into the FIFO
    bus.db_req_ready = 1'b0;
    send(96'hAA, 4'h1, 1'b1);
    tick(); bus.in_valid = 1'b0;
    tick();
    chk("ov_parked", 128'(bus.db_req_valid), 128'(1));
    for (int i = 0; i < 10; i++) begin
      send(96'h5EED_0000 + 96'(i), 4'(i + 2), i < 8);
      tick();
    end
    bus.in_valid = 1'b0;
    chk("ov_drop_cnt", 128'(bus.drop_cnt), 128'(2));
    chk("ov_busy", 128'(bus.busy), 128'(1));
    o = out_cnt;
    t = hs_cnt;
    bus.db_req_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      wait_hs(t + i + 1);
      reply(4'(i + 7));
    end
    tick(); tick();
    chk("ov_out_count", 128'(out_cnt - o), 128'(9));
    chk("ov_busy_end", 128'(bus.busy), 128'(0));

    // Timeout (TIMEOUT=16), then a late reply
    t = hs_cnt;
    send(96'h7137, 4'b1111, 1'b1);
    tick(); bus.in_valid = 1'b0;
    wait_hs(t + 1);                          // accept cycle + 1
    rsp_q.push_back({4'b0000, cur_key});
    for (int i = 0; i < 14; i++) tick();     // accept + 15
    chk("tmo_not_yet", 128'(bus.out_valid), 128'(0));
    tick();                                  // accept + 16
    chk("tmo_out", 128'(bus.out_valid), 128'(1));
    chk("tmo_flag", 128'(bus.out_flag), 128'(0));
    chk("tmo_key", 128'(bus.out_key), 128'(96'h7137));
    chk("tmo_cnt", 128'(bus.timeout_cnt), 128'(1));
    tick(); tick();
    bus.db_rsp_valid = 1'b1; bus.db_rsp_flag = 4'b0100;
    tick(); bus.db_rsp_valid = 1'b0;
    chk("late_none1", 128'(bus.out_valid), 128'(0));
    tick();
    chk("late_none2", 128'(bus.out_valid), 128'(0));
    tick();

    // Race: reply lands exactly when the timer expires
    t = hs_cnt;
    send(96'hACE, 4'b0010, 1'b1);
    tick(); bus.in_valid = 1'b0;
    wait_hs(t + 1);
    for (int i = 0; i < 14; i++) tick();
    reply(4'b0110);
    chk("race_out", 128'(bus.out_valid), 128'(1));
    chk("race_flag", 128'(bus.out_flag), 128'(4'b0110));
    chk("race_tmo_cnt", 128'(bus.timeout_cnt), 128'(1));
    tick();
    bus.db_rsp_valid = 1'b1; bus.db_rsp_flag = 4'b1010;
    tick(); bus.db_rsp_valid = 1'b0;
    chk("stray_none1", 128'(bus.out_valid), 128'(0));
    tick();
    chk("stray_none2", 128'(bus.out_valid), 128'(0));
    chk("stray_flag_hold", 128'(bus.out_flag), 128'(4'b0110));

    // Reset in WAIT, then a reply that must be ignored
    t = hs_cnt;
    send(96'hBAD, 4'b0001, 1'b1);
    tick(); bus.in_valid = 1'b0;
    wait_hs(t + 1);
    eth_rst_n = 1'b0;
    tick();
    eth_rst_n = 1'b1;
    bus.db_rsp_valid = 1'b1; bus.db_rsp_flag = 4'b0100;
    tick(); bus.db_rsp_valid = 1'b0;
    chk("rw_out1", 128'(bus.out_valid), 128'(0));
    tick();
    chk("rw_out2", 128'(bus.out_valid), 128'(0));
    chk("rw_drop", 128'(bus.drop_cnt), 128'(0));
    chk("rw_tmo", 128'(bus.timeout_cnt), 128'(0));
    chk("rw_busy", 128'(bus.busy), 128'(0));
    chk("rw_req_valid", 128'(bus.db_req_valid), 128'(0));
    chk("rw_out_key", 128'(bus.out_key), 128'(0));

    chk("sb_req_empty", 128'(req_q.size()), 128'(0));
    chk("sb_rsp_empty", 128'(rsp_q.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
